// File: rtl/instr_grp_dec_unit.sv
// rtl/instr_grp_dec_unit.sv - registered instruction group classifier and field decoder for spcpu
module instr_grp_dec_unit #(
  parameter int INSTR_W = 16,
  parameter int RIND_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr_hi,
  input  logic               instr_valid,
  output logic               out_valid,
  output logic [2:0]         group_out,
  output logic               is_32_bit,
  output logic [2:0]         ig1_opcode,
  output logic [RIND_W-1:0]  ig1_ra_index,
  output logic [7:0]         ig1_imm8,
  output logic               ig1_changes_pc,
  output logic [3:0]         ig2_opcode,
  output logic [RIND_W-1:0]  ig2_ra_index,
  output logic [RIND_W-1:0]  ig2_rb_index,
  output logic               ig2_changes_pc
);

  // Group codes as seen on group_out.
  localparam logic [2:0] GRP_UNKNOWN = 3'd0;
  localparam logic [2:0] GRP_1       = 3'd1;
  localparam logic [2:0] GRP_2       = 3'd2;
  localparam logic [2:0] GRP_3       = 3'd3;
  localparam logic [2:0] GRP_4       = 3'd4;
  localparam logic [2:0] GRP_5       = 3'd5;

  // Group-1 opcode that only sets flags (cpi).
  localparam logic [2:0] IG1_CPI = 3'd4;

  // Group-2 opcodes with non-default destination behaviour.
  localparam logic [3:0] IG2_CMP = 4'd4;
  localparam logic [3:0] IG2_SWP = 4'd14;
  localparam logic [3:0] IG2_TST = 4'd15;

  // PC pair register indices.
  localparam logic [RIND_W-1:0] REG_PC_HI = RIND_W'(14);
  localparam logic [RIND_W-1:0] REG_PC_LO = RIND_W'(15);

  // Registered decode state.
  logic              valid_q;
  logic [2:0]        group_q,     group_d;
  logic [2:0]        ig1_op_q,    ig1_op_d;
  logic [RIND_W-1:0] ig1_ra_q,    ig1_ra_d;
  logic [7:0]        ig1_imm_q,   ig1_imm_d;
  logic              ig1_pc_q,    ig1_pc_d;
  logic [3:0]        ig2_op_q,    ig2_op_d;
  logic [RIND_W-1:0] ig2_ra_q,    ig2_ra_d;
  logic [RIND_W-1:0] ig2_rb_q,    ig2_rb_d;
  logic              ig2_pc_q,    ig2_pc_d;

  // Intermediate decode terms.
  logic [3:0] top_nib;
  logic       ig1_ra_is_pc;
  logic       ig2_ra_is_pc;
  logic       ig2_rb_is_pc;
  logic       ig2_writes_ra;
  logic       ig2_writes_rb;

  function automatic logic is_pc_reg(input logic [RIND_W-1:0] idx);
    return (idx == REG_PC_HI) || (idx == REG_PC_LO);
  endfunction

  assign top_nib = instr_hi[INSTR_W-1 -: 4];

  // Classify the word into its instruction group from the top nibble.
  always_comb begin
    group_d = GRP_UNKNOWN;
    casez (top_nib)
      4'b0???: group_d = GRP_1;
      4'b1000: group_d = GRP_2;
      4'b1001: group_d = GRP_UNKNOWN;
      4'b101?: group_d = GRP_3;
      4'b110?: group_d = GRP_4;
      4'b1110: group_d = GRP_5;
      4'b1111: group_d = GRP_UNKNOWN;
      default: group_d = GRP_UNKNOWN;
    endcase
  end

  // Raw field extraction; fields are presented whatever the group, so the
  // execute stage can pick them up without another mux.
  always_comb begin
    ig1_op_d  = instr_hi[14:12];
    ig1_ra_d  = instr_hi[11:8];
    ig1_imm_d = instr_hi[7:0];
    ig2_op_d  = instr_hi[11:8];
    ig2_ra_d  = instr_hi[7:4];
    ig2_rb_d  = instr_hi[3:0];
  end

  // Destination-register analysis for the PC-write flags.
  always_comb begin
    ig1_ra_is_pc  = is_pc_reg(ig1_ra_d);
    ig2_ra_is_pc  = is_pc_reg(ig2_ra_d);
    ig2_rb_is_pc  = is_pc_reg(ig2_rb_d);
    // cmp and tst only update flags; swp is the sole op that writes rb too.
    ig2_writes_ra = (ig2_op_d != IG2_CMP) && (ig2_op_d != IG2_TST);
    ig2_writes_rb = (ig2_op_d == IG2_SWP);
  end

  // PC-write flags, gated by the group so stray field values never alias.
  always_comb begin
    ig1_pc_d = (group_d == GRP_1) && (ig1_op_d != IG1_CPI) && ig1_ra_is_pc;
    ig2_pc_d = (group_d == GRP_2) &&
               ((ig2_writes_ra && ig2_ra_is_pc) || (ig2_writes_rb && ig2_rb_is_pc));
  end

  // Valid pipeline bit follows the input every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= instr_valid;
    end
  end

  // Decode registers load only on a valid word and otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      group_q   <= GRP_UNKNOWN;
      ig1_op_q  <= '0;
      ig1_ra_q  <= '0;
      ig1_imm_q <= '0;
      ig1_pc_q  <= 1'b0;
      ig2_op_q  <= '0;
      ig2_ra_q  <= '0;
      ig2_rb_q  <= '0;
      ig2_pc_q  <= 1'b0;
    end else if (instr_valid) begin
      group_q   <= group_d;
      ig1_op_q  <= ig1_op_d;
      ig1_ra_q  <= ig1_ra_d;
      ig1_imm_q <= ig1_imm_d;
      ig1_pc_q  <= ig1_pc_d;
      ig2_op_q  <= ig2_op_d;
      ig2_ra_q  <= ig2_ra_d;
      ig2_rb_q  <= ig2_rb_d;
      ig2_pc_q  <= ig2_pc_d;
    end
  end

  // is_32_bit comes from the registered group so the two never disagree.
  assign is_32_bit      = (group_q == GRP_5);
  assign out_valid      = valid_q;
  assign group_out      = group_q;
  assign ig1_opcode     = ig1_op_q;
  assign ig1_ra_index   = ig1_ra_q;
  assign ig1_imm8       = ig1_imm_q;
  assign ig1_changes_pc = ig1_pc_q;
  assign ig2_opcode     = ig2_op_q;
  assign ig2_ra_index   = ig2_ra_q;
  assign ig2_rb_index   = ig2_rb_q;
  assign ig2_changes_pc = ig2_pc_q;

endmodule

// File: tb/tb_instr_grp_dec_unit.sv
// tb/tb_instr_grp_dec_unit.sv - self-checking bench for instr_grp_dec_unit
module tb_instr_grp_dec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr_hi = '0;
  logic        instr_valid = 1'b0;
  logic        out_valid;
  logic [2:0]  group_out;
  logic        is_32_bit;
  logic [2:0]  ig1_opcode;
  logic [3:0]  ig1_ra_index;
  logic [7:0]  ig1_imm8;
  logic        ig1_changes_pc;
  logic [3:0]  ig2_opcode;
  logic [3:0]  ig2_ra_index;
  logic [3:0]  ig2_rb_index;
  logic        ig2_changes_pc;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic       ov;
    logic [2:0] grp;
    logic       is32;
    logic [2:0] op1;
    logic [3:0] ra1;
    logic [7:0] imm;
    logic       pc1;
    logic [3:0] op2;
    logic [3:0] ra2;
    logic [3:0] rb2;
    logic       pc2;
  } dec_t;

  dec_t exp_q;

  instr_grp_dec_unit dut (
    .clk(clk), .reset(reset), .instr_hi(instr_hi), .instr_valid(instr_valid),
    .out_valid(out_valid), .group_out(group_out), .is_32_bit(is_32_bit),
    .ig1_opcode(ig1_opcode), .ig1_ra_index(ig1_ra_index), .ig1_imm8(ig1_imm8),
    .ig1_changes_pc(ig1_changes_pc), .ig2_opcode(ig2_opcode),
    .ig2_ra_index(ig2_ra_index), .ig2_rb_index(ig2_rb_index),
    .ig2_changes_pc(ig2_changes_pc)
  );

  always #5 clk = ~clk;

  function automatic dec_t observed();
    dec_t o;
    o = {out_valid, group_out, is_32_bit, ig1_opcode, ig1_ra_index, ig1_imm8,
         ig1_changes_pc, ig2_opcode, ig2_ra_index, ig2_rb_index, ig2_changes_pc};
    return o;
  endfunction

  // Reference: decode straight from the instruction-set rules.
  function automatic dec_t model(input logic [15:0] w);
    dec_t e;
    int   nib, op1, ra1, op2, ra2, rb2;
    bit   wr_ra, wr_rb;
    nib = int'(w >> 12);
    op1 = int'((w >> 12) & 16'h7);
    ra1 = int'((w >> 8) & 16'hF);
    op2 = int'((w >> 8) & 16'hF);
    ra2 = int'((w >> 4) & 16'hF);
    rb2 = int'(w & 16'hF);
    if (nib < 8)       e.grp = 3'd1;
    else if (nib == 8) e.grp = 3'd2;
    else if (nib == 9) e.grp = 3'd0;
    else if (nib < 12) e.grp = 3'd3;
    else if (nib < 14) e.grp = 3'd4;
    else if (nib == 14) e.grp = 3'd5;
    else               e.grp = 3'd0;
    e.ov   = 1'b1;
    e.is32 = (e.grp == 3'd5);
    e.op1  = 3'(op1);
    e.ra1  = 4'(ra1);
    e.imm  = 8'(w % 256);
    e.op2  = 4'(op2);
    e.ra2  = 4'(ra2);
    e.rb2  = 4'(rb2);
    e.pc1  = (e.grp == 3'd1) && (op1 != 4) && (ra1 == 14 || ra1 == 15);
    wr_ra  = !(op2 == 4 || op2 == 15);
    wr_rb  = (op2 == 14);
    e.pc2  = (e.grp == 3'd2) && ((wr_ra && (ra2 == 14 || ra2 == 15)) ||
                                 (wr_rb && (rb2 == 14 || rb2 == 15)));
    return e;
  endfunction

  // Apply one word for one edge and advance the expected register image.
  task automatic cycle(input logic [15:0] w, input logic v);
    instr_hi    = w;
    instr_valid = v;
    @(posedge clk);
    #1;
    if (v) exp_q = model(w);
    else   exp_q.ov = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (observed() !== '0) $display("FAIL reset_init: got %h want 0", observed());
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    exp_q = '0;
    cycle(16'h7E05, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    exp_q = '0;
    n_checks++;
    if (observed() !== '0) $display("FAIL reset_async: got %h want 0", observed());
    else n_pass++;
    n_checks++;
    if (group_out !== 3'd0) $display("FAIL reset_group: got %0d want 0", group_out);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    cycle(16'h0000, 1'b1);
    n_checks++;
    if (observed() !== exp_q) $display("FAIL first_after_reset: got %h want %h", observed(), exp_q);
    else n_pass++;
    n_checks++;
    if (group_out !== 3'd1 || out_valid !== 1'b1 || ig1_imm8 !== 8'h00)
      $display("FAIL first_fields: grp %0d ov %0b imm %h want 1 1 00", group_out, out_valid, ig1_imm8);
    else n_pass++;
  endtask

  task automatic test_group1();
    cycle(16'h7E05, 1'b1);
    n_checks++;
    if (observed() !== exp_q) $display("FAIL g1_cpyi: got %h want %h", observed(), exp_q);
    else n_pass++;
    n_checks++;
    if (group_out !== 3'd1 || ig1_opcode !== 3'd7 || ig1_ra_index !== 4'd14 ||
        ig1_imm8 !== 8'h05 || ig1_changes_pc !== 1'b1)
      $display("FAIL g1_cpyi_fields: grp %0d op %0d ra %0d imm %h pc %0b want 1 7 14 05 1",
               group_out, ig1_opcode, ig1_ra_index, ig1_imm8, ig1_changes_pc);
    else n_pass++;
    cycle(16'h4F10, 1'b1);
    n_checks++;
    if (ig1_changes_pc !== 1'b0) $display("FAIL g1_cpi_pc: got %0b want 0", ig1_changes_pc);
    else n_pass++;
  endtask

  task automatic test_group2();
    logic [15:0] words [3] = '{16'h80F3, 16'h8E2E, 16'h84E1};
    logic        pcs   [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      cycle(words[i], 1'b1);
      n_checks++;
      if (observed() !== exp_q) $display("FAIL g2_word%0d: got %h want %h", i, observed(), exp_q);
      else n_pass++;
      n_checks++;
      if (group_out !== 3'd2 || ig2_changes_pc !== pcs[i] || ig1_changes_pc !== 1'b0)
        $display("FAIL g2_pc%0d: grp %0d pc2 %0b pc1 %0b want 2 %0b 0",
                 i, group_out, ig2_changes_pc, ig1_changes_pc, pcs[i]);
      else n_pass++;
    end
    n_checks++;
    if (ig2_opcode !== 4'd4 || ig2_ra_index !== 4'd14 || ig2_rb_index !== 4'd1)
      $display("FAIL g2_cmp_fields: op %0d ra %0d rb %0d want 4 14 1",
               ig2_opcode, ig2_ra_index, ig2_rb_index);
    else n_pass++;
  endtask

  task automatic test_classify();
    logic [15:0] words [5] = '{16'h9000, 16'hA000, 16'hC000, 16'hE000, 16'hF000};
    logic [2:0]  grps  [5] = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd0};
    for (int i = 0; i < 5; i++) begin
      cycle(words[i] | 16'(($urandom % 2) ? 16'h0EFE : 16'h0000), 1'b1);
      n_checks++;
      if (observed() !== exp_q) $display("FAIL classify%0d: got %h want %h", i, observed(), exp_q);
      else n_pass++;
      n_checks++;
      if (group_out !== grps[i] || is_32_bit !== (grps[i] == 3'd5) ||
          ig1_changes_pc !== 1'b0 || ig2_changes_pc !== 1'b0)
        $display("FAIL classify_grp%0d: grp %0d is32 %0b pc %0b%0b want %0d",
                 i, group_out, is_32_bit, ig1_changes_pc, ig2_changes_pc, grps[i]);
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    dec_t held;
    cycle(16'h7E05, 1'b1);
    held = exp_q;
    for (int i = 0; i < 3; i++) begin
      cycle(16'($urandom), 1'b0);
      held.ov = 1'b0;
      n_checks++;
      if (observed() !== held) $display("FAIL hold%0d: got %h want %h", i, observed(), held);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3] = '{16'h80F3, 16'hE000, 16'h1234};
    logic [2:0]  grps  [3] = '{3'd2, 3'd5, 3'd1};
    for (int i = 0; i < 3; i++) begin
      cycle(words[i], 1'b1);
      n_checks++;
      if (observed() !== exp_q || group_out !== grps[i] || out_valid !== 1'b1)
        $display("FAIL b2b%0d: got %h want %h (grp %0d)", i, observed(), exp_q, grps[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int i = 0; i < 300; i++) begin
      w = 16'($urandom);
      if (($urandom % 4) == 0) w[15:12] = 4'h8;
      if (($urandom % 4) == 0) w[11:8] = 4'hE | 4'($urandom % 2);
      cycle(w, 1'(($urandom % 4) != 0));
      n_checks++;
      if (observed() !== exp_q) $display("FAIL random%0d: word %h got %h want %h", i, w, observed(), exp_q);
      else n_pass++;
    end
  endtask

  initial begin
    exp_q = '0;
    test_reset();
    test_group1();
    test_group2();
    test_classify();
    test_hold();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_grp_dec_unit.md
Name: instr_grp_dec_unit

Overview:
- Registered front-end instruction decoder for the 16-bit spcpu core.
- Classifies a fetched 16-bit instruction word (the full instruction, or the high half of a 32-bit instruction) into instruction group 1..5 or unknown.
- Extracts and decodes group-1 (register/immediate) and group-2 (register/register) fields, and flags writes to the PC pair r14:r15.
- Feeds the CPU's execute state machine; one-cycle latency.

Parameters:
- INSTR_W, 16, instruction half-word width.
- RIND_W, 4, register index width (16 registers; PC = r14 hi, r15 lo).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- instr_hi  input  16  instruction word to decode.
- instr_valid  input  1  instr_hi is valid this cycle; decode registers load only when high.
- out_valid  output  1  registered copy of instr_valid.
- group_out  output  3  0 = unknown, 1..5 = group 1..5.
- is_32_bit  output  1  high iff group_out == 5.
- ig1_opcode  output  3  instr[14:12].
- ig1_ra_index  output  4  instr[11:8].
- ig1_imm8  output  8  instr[7:0].
- ig1_changes_pc  output  1  group-1 instruction writes r14 or r15.
- ig2_opcode  output  4  instr[11:8].
- ig2_ra_index  output  4  instr[7:4].
- ig2_rb_index  output  4  instr[3:0].
- ig2_changes_pc  output  1  group-2 instruction writes r14 or r15.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous, active-high. While reset is high, every output is 0, including group_out = unknown.
- Group classification, by instr[15:12]:
  - 0xxx → grp 1
  - 1000 → grp 2
  - 1001 → unknown
  - 101x → grp 3
  - 110x → grp 4
  - 1110 → grp 5 (32-bit)
  - 1111 → unknown
- Field extraction: fields are taken from the raw bits regardless of group. Only the changes_pc flags are gated by group.
- Group-1 opcodes:
  - 0 addi, 1 adci, 2 subi, 3 sbci, 4 cpi, 5 andi, 6 orri, 7 cpyi.
  - All write ra except cpi (4).
  - ig1_changes_pc = (group == 1) && opcode != 4 && ra_index ∈ {14, 15}.
- Group-2 opcodes:
  - 0 add, 1 adc, 2 sub, 3 sbc, 4 cmp, 5 and, 6 orr, 7 xor, 8 lsl, 9 lsr, 10 asr, 11 rol, 12 ror, 13 cpy, 14 swp, 15 tst.
  - cmp and tst write nothing.
  - swp writes both ra and rb.
  - All others write ra only.
  - ig2_changes_pc = (group == 2) && ((writes ra && ra ∈ {14, 15}) || (opcode == 14 && rb ∈ {14, 15})).
- Timing:
  - On a rising edge with instr_valid = 1, all decode outputs load the decode of instr_hi, visible the next cycle.
  - With instr_valid = 0, decode outputs hold their previous values.
  - out_valid <= instr_valid every edge.
- is_32_bit is derived from the registered group_out, so it is consistent with it in the same cycle.
- Reset asserted mid-stream clears outputs immediately. The first valid word after reset deassertion decodes normally.
- Back-to-back valid words each decode with 1-cycle latency, without bubbles.

Test Plan:
- Reset: assert reset asynchronously between edges → all outputs 0 at once, group_out = 0. Release, then instr_hi = 16'h0000 valid → next cycle group_out = 1, ig1_opcode = 0, ra = 0, imm8 = 8'h00, out_valid = 1.
- Group-1 PC write: instr_hi = 16'h7E05 (cpyi r14, #5) → group 1, opcode 7, ra 14, imm8 8'h05, ig1_changes_pc = 1. Then 16'h4F10 (cpi r15) → ig1_changes_pc = 0.
- Group-2: instr_hi = 16'h80F3 (add r15, r3) → group 2, opcode 0, ra 15, rb 3, ig2_changes_pc = 1. Then 16'h8E2E (swp r2, r14) → changes_pc = 1. Then 16'h84E1 (cmp r14, r1) → changes_pc = 0.
- Classification sweep: 16'h9000 → 0, 16'hA000 → 3, 16'hC000 → 4, 16'hE000 → 5 with is_32_bit = 1, 16'hF000 → 0. Every non-group-1/2 word → both changes_pc = 0.
- Hold: valid 16'h7E05, then instr_valid = 0 while instr_hi toggles randomly for 3 cycles → outputs unchanged, out_valid = 0.
- Back-to-back: valid words 16'h80F3, 16'hE000, 16'h1234 on consecutive cycles → outputs track each word exactly one cycle later (group 2, 5, 1).
